// File: rtl/ram1_ctrl.sv
// RAM1 access sequencer: turns MEM-stage req/ack into IDLE/SETUP/ACCESS/DONE strobes for the pin driver.
// Optional RAM1_POSTED_WRITE_EN: writes ack in SETUP while the FSM finishes the access internally.
module ram1_ctrl #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_write,
  output logic              ram_ce_n,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CNT_W    = 3;
  localparam int unsigned WAIT_EFF = (WAIT_CYCLES > 7) ? 7 : WAIT_CYCLES;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] SETUP  = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;
  localparam logic [1:0] DONE   = 2'b11;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic             r_posted;

  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_we_nxt;
  logic              w_posted_nxt;
  logic              w_ack_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic              w_write_nxt;
  logic              w_ce_n_nxt;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_posted  <= 1'b0;
      ack       <= 1'b0;
      rdata     <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_write <= 1'b0;
      ram_ce_n  <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_we      <= w_we_nxt;
      r_posted  <= w_posted_nxt;
      ack       <= w_ack_nxt;
      rdata     <= w_rdata_nxt;
      ram_addr  <= w_addr_nxt;
      ram_wdata <= w_wdata_nxt;
      ram_write <= w_write_nxt;
      ram_ce_n  <= w_ce_n_nxt;
    end
  end

  // Next state; output values are those required in the state being entered
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_we_nxt     = r_we;
    w_posted_nxt = r_posted;
    w_ack_nxt    = 1'b0;
    w_rdata_nxt  = rdata;
    w_addr_nxt   = ram_addr;
    w_wdata_nxt  = ram_wdata;
    w_write_nxt  = 1'b0;
    w_ce_n_nxt   = 1'b1;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_state_nxt = SETUP;
          w_we_nxt    = req_we;
          w_addr_nxt  = req_addr;
          w_wdata_nxt = req_wdata;
          w_ce_n_nxt  = 1'b0;
`ifdef RAM1_POSTED_WRITE_EN
          w_posted_nxt = req_we;
          w_ack_nxt    = req_we;
`else
          w_posted_nxt = 1'b0;
`endif
        end
      end
      SETUP: begin
        w_state_nxt = ACCESS;
        w_cnt_nxt   = CNT_W'(WAIT_EFF);
        w_ce_n_nxt  = 1'b0;
        w_write_nxt = r_we;
      end
      ACCESS: begin
        if (r_cnt == '0) begin
          // Read data is sampled on the edge that closes the last OE-low half cycle
          w_state_nxt = DONE;
          w_ack_nxt   = !r_posted;
          if (!r_we) w_rdata_nxt = ram_rdata;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
          w_ce_n_nxt  = 1'b0;
          w_write_nxt = r_we;
        end
      end
      DONE: begin
        w_state_nxt  = IDLE;
        w_posted_nxt = 1'b0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Posted writes release the pipeline in SETUP; later requests still wait for IDLE
  always_comb begin
    stall = 1'b1;
    if (r_state == IDLE) stall = req;
    else if (r_posted)   stall = (r_state == SETUP) ? 1'b0 : req;
  end

endmodule

// File: tb/tb_ram1_ctrl.sv
// Bench for ram1_ctrl: two instances (WAIT_CYCLES 0 and 2), an emulated RAM1 device and a reference memory model.
module tb_ram1_ctrl;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
`ifdef RAM1_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req       [2];
  logic          req_we    [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic          ack       [2];
  logic [DW-1:0] rdata     [2];
  logic          stall     [2];
  logic [AW-1:0] ram_addr  [2];
  logic [DW-1:0] ram_wdata [2];
  logic          ram_write [2];
  logic          ram_ce_n  [2];
  logic [DW-1:0] ram_rdata [2];

  int  n_assert = 0;
  int  n_fail   = 0;
  int  we_pulses [2];
  time t_ack [2];
  logic [DW-1:0] dev_mem [int];
  logic [DW-1:0] ref_mem [int];

  always #5 clk = ~clk;

  ram1_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req[0]), .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .stall(stall[0]),
    .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_write(ram_write[0]),
    .ram_ce_n(ram_ce_n[0]), .ram_rdata(ram_rdata[0]));

  ram1_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) u_dut1 (
    .clk(clk), .rst(rst), .req(req[1]), .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .stall(stall[1]),
    .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_write(ram_write[1]),
    .ram_ce_n(ram_ce_n[1]), .ram_rdata(ram_rdata[1]));

  function automatic int wait_of(input int u);
    return (u == 0) ? 0 : 2;
  endfunction

  function automatic int key_of(input int u, input logic [AW-1:0] a);
    return u * (1 << AW) + int'(a);
  endfunction

  function automatic logic [DW-1:0] init_val(input int key);
    return DW'(key * 7 + 165);
  endfunction

  // RAM1 as seen through the driver: strobes act during clk low
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!ram_ce_n[u] && ram_write[u]) begin
        dev_mem[key_of(u, ram_addr[u])] = ram_wdata[u];
        we_pulses[u]++;
        ram_rdata[u] <= 16'hDEAD;
      end else if (!ram_ce_n[u]) begin
        ram_rdata[u] <= dev_mem.exists(key_of(u, ram_addr[u])) ?
                        dev_mem[key_of(u, ram_addr[u])] : init_val(key_of(u, ram_addr[u]));
      end else begin
        ram_rdata[u] <= 16'hDEAD;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request; pre = edges before the controller can accept, stall0 = stall right after driving
  task automatic access(input int u, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int pre, input logic stall0, input bit hold);
    int w, key, exp_ack, cyc, wcyc, p0, n;
    bit got, posted_w;
    logic [DW-1:0] exp_rd;
    w = wait_of(u);
    key = key_of(u, a);
    posted_w = POSTED && we;
    exp_ack = pre + (posted_w ? 1 : 3 + w);
    exp_rd = ref_mem.exists(key) ? ref_mem[key] : init_val(key);
    if (we) ref_mem[key] = d;
    cyc = 0; wcyc = 0; got = 1'b0; p0 = we_pulses[u];
    req[u] = 1'b1; req_we[u] = we; req_addr[u] = a; req_wdata[u] = d;
    #1;
    chk("stall_on_req", stall[u], stall0);
    while (!got && cyc < 20) begin
      step();
      cyc++;
      if (cyc == pre + 1) begin
        req_we[u] = 1'($urandom); req_addr[u] = AW'($urandom); req_wdata[u] = DW'($urandom);
      end
      if (cyc > pre && ram_write[u]) wcyc++;
      if (cyc > pre && !ram_ce_n[u]) begin
        chk("addr_hold", ram_addr[u], a);
        if (we) chk("wdata_hold", ram_wdata[u], d);
      end
      if (ack[u]) got = 1'b1;
      else chk("stall_busy", stall[u], 1);
    end
    t_ack[u] = $time;
    chk("ack_seen", got, 1);
    chk("ack_cycle", cyc, exp_ack);
    chk("stall_at_ack", stall[u], posted_w ? 0 : 1);
    if (!we) chk("rdata", rdata[u], exp_rd);
    if (!posted_w) begin
      chk("done_addr", ram_addr[u], a);
      chk("done_ce_n", ram_ce_n[u], 1);
      chk("done_write", ram_write[u], 0);
      chk("write_cycles", wcyc, we ? w + 1 : 0);
      if (we) chk("we_pulses", we_pulses[u] - p0, w + 1);
    end
    if (!hold) begin
      req[u] = 1'b0; req_we[u] = 1'b0;
      n = 0;
      while (!ram_ce_n[u] && n < 20) begin
        step();
        n++;
      end
      if (posted_w) begin
        chk("posted_no_done_ack", ack[u], 0);
        chk("we_pulses_posted", we_pulses[u] - p0, w + 1);
      end
      step();
      chk("idle_ack", ack[u], 0);
      chk("idle_ce_n", ram_ce_n[u], 1);
      chk("idle_stall", stall[u], 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    time t0;
    logic [AW-1:0] a;
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      req[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = '0; req_wdata[u] = '0; we_pulses[u] = 0;
    end
    step();
    for (int u = 0; u < 2; u++) begin
      chk("rst_ack", ack[u], 0);
      chk("rst_rdata", rdata[u], 0);
      chk("rst_addr", ram_addr[u], 0);
      chk("rst_wdata", ram_wdata[u], 0);
      chk("rst_write", ram_write[u], 0);
      chk("rst_ce_n", ram_ce_n[u], 1);
      chk("rst_stall", stall[u], 0);
    end
    rst = 1'b1;
    step();

    // Directed write then read, zero wait states
    access(0, 1'b1, 18'h00123, 16'hBEEF, 0, 1'b1, 1'b0);
    chk("dev_mem_123", dev_mem[key_of(0, 18'h00123)], 16'hBEEF);
    access(0, 1'b0, 18'h00123, 16'h0000, 0, 1'b1, 1'b0);
    repeat (5) step();
    chk("rdata_held", rdata[0], 16'hBEEF);

    // Two wait states at the top of the address range
    access(1, 1'b0, 18'h3FFFF, 16'h0000, 0, 1'b1, 1'b0);
    access(1, 1'b1, 18'h3FFFF, 16'hC0DE, 0, 1'b1, 1'b0);
    access(1, 1'b0, 18'h3FFFF, 16'h0000, 0, 1'b1, 1'b0);

    // Back-to-back with req held through the write's ack
    access(0, 1'b1, 18'h00001, 16'h1234, 0, 1'b1, 1'b1);
    t0 = t_ack[0];
    access(0, 1'b0, 18'h00001, 16'h0000, POSTED ? 3 : 1, POSTED ? 1'b0 : 1'b1, 1'b0);
    chk("b2b_spacing", ((t_ack[0] - t0) / 10) >= 4, 1);
    chk("b2b_rdata", rdata[0], 16'h1234);

    // Reset in the middle of a WAIT_CYCLES=2 write
    req[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 18'h00020; req_wdata[1] = 16'h7777;
    step(); step(); step();
    chk("abort_pre_write", ram_write[1], 1);
    rst = 1'b0;
    #1;
    chk("abort_ce_n", ram_ce_n[1], 1);
    chk("abort_write", ram_write[1], 0);
    chk("abort_ack", ack[1], 0);
    req[1] = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_ack", ack[1], 0);
      chk("abort_idle_ce", ram_ce_n[1], 1);
    end

    // Random traffic against the reference memory
    for (int i = 0; i < 48; i++) begin
      a = ($urandom_range(0, 4) == 0) ? 18'h3FFFF : AW'($urandom_range(0, 7));
      access(i % 2, 1'($urandom), a, DW'($urandom), 0, 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ram1_ctrl.md
Name: ram1_ctrl

Overview:
- Multi-cycle access sequencer directly upstream of the RAM1 pin driver.
- Accepts single-word read/write requests from the CPU MEM stage over a req/ack handshake.
- Drives the driver's address, write data and read/write select, plus the RAM1 chip-enable.
- Holds address and data stable across the access, captures read data and raises a stall to the pipeline while busy.

Parameters:
- ADDR_W, 18: word address width, matches the RAM1 address bus.
- DATA_W, 16: data width.
- WAIT_CYCLES, 0: extra ACCESS cycles inserted per access (0..7).

Ports:
- clk  input  1  system clock; the driver strobes OE/WE during clk low.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  MEM-stage access request; held high until ack.
- req_we  input  1  1 = write, 0 = read; sampled with req.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- ack  output  1  one-cycle completion pulse.
- rdata  output  DATA_W  read result; valid while ack=1, held afterwards.
- stall  output  1  high whenever state != IDLE, or when req=1 in IDLE.
- ram_addr  output  ADDR_W  to driver addr.
- ram_wdata  output  DATA_W  to driver data.
- ram_write  output  1  to driver read select (0 = read, 1 = write).
- ram_ce_n  output  1  RAM1 chip enable, active low.
- ram_rdata  input  DATA_W  RAM1 data bus as seen from the driver.

Behaviour:
- Reset (async, rst=0): state=IDLE, ack=0, rdata=0, ram_addr=0, ram_wdata=0, ram_write=0, ram_ce_n=1, wait counter=0. Reset mid-access aborts the access immediately; no ack is issued.
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered except stall.
- IDLE:
  - ram_ce_n=1, ram_write=0.
  - On a clk edge with req=1: latch req_we/addr/wdata into ram_addr/ram_wdata and an internal we bit; go to SETUP.
- SETUP (1 cycle):
  - ram_ce_n=0, ram_write=0. Address and data are stable.
  - The driver tri-states the bus because ram_write=0.
  - Load wait counter with WAIT_CYCLES; go to ACCESS.
- ACCESS (WAIT_CYCLES+1 cycles):
  - ram_ce_n=0, ram_write=we.
  - Counter decrements each cycle; leave for DONE when the counter is 0.
  - Read: rdata <= ram_rdata on the rising edge that ends the last ACCESS cycle (OE was low during that cycle's low half).
  - Write: WE pulses once per ACCESS cycle; repeated pulses are legal because address and data are unchanged.
- DONE (1 cycle):
  - ack=1, ram_write=0, ram_ce_n=1; ram_addr/ram_wdata still held.
  - Next state is IDLE. A req still high in DONE is not a new request; the requester drops req on seeing ack.
- Latency: ack is high in the 3rd+WAIT_CYCLES cycle after req is sampled. WAIT_CYCLES=0 gives req-sample edge → SETUP → ACCESS → DONE.
- Back-to-back requests: a new req is accepted no earlier than the first IDLE edge after DONE. Minimum spacing is 4+WAIT_CYCLES cycles.
- Write → ram_write=0 transition happens only on entry to DONE, with address and data unchanged that cycle (hold time).
- Changes to req_addr/req_wdata/req_we after acceptance are ignored.
- WAIT_CYCLES above 7 is clamped to 7 (3-bit counter).

Optional Feature:
- Macro: RAM1_POSTED_WRITE_EN.
- Defined:
  - Writes ack in the SETUP cycle, one cycle after acceptance; stall drops with that ack.
  - The FSM continues through ACCESS/DONE internally, with DONE issuing no ack for a posted write.
  - A new req arriving before IDLE is held off by stall=1 until IDLE.
  - Reads are unchanged.
- Undefined: all accesses ack in DONE, as above.

Test Plan:
- Reset: rst=0 during an ACCESS write → ram_ce_n=1, ram_write=0 and ack=0 immediately; after rst=1 the FSM is IDLE and no ack appears.
- Write, WAIT_CYCLES=0: req_we=1, addr=0x00123, wdata=0xBEEF → ram_addr/ram_wdata held; ram_write=1 for exactly 1 cycle; ack on cycle 3; model memory[0x123]=0xBEEF.
- Read: addr=0x00123, model returns 0xBEEF → rdata=0xBEEF with ack on cycle 3; rdata still 0xBEEF 5 cycles later.
- WAIT_CYCLES=2 read of 0x3FFFF (max address) → ram_write=0 and ACCESS lasting 3 cycles; ack on cycle 5; correct data returned.
- Back-to-back: write 0x0001←0x1234 with req held high, then read 0x0001 → exactly 2 acks; read ack no earlier than 4 cycles after the write ack's predecessor sample; rdata=0x1234; stall high throughout except the accepting edges.
- With RAM1_POSTED_WRITE_EN: write 0x0002←0x5A5A → ack in the SETUP cycle; a following read req is stalled until IDLE, then returns 0x5A5A.
